// File: rtl/signed_sat_accumulator_if.sv
// Sample-in / frame-result-out bundle for signed_sat_accumulator.
// slave is the accumulator's view; master is the producer/consumer side.
interface signed_sat_accumulator_if #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
);
    logic                    i_clear;
    logic [CNT_W-1:0]        i_len;
    logic                    i_valid;
    logic                    o_ready;
    logic signed [IN_W-1:0]  i_data;
    logic                    o_valid;
    logic                    i_ready;
    logic signed [ACC_W-1:0] o_data;
    logic                    o_sat;
    logic                    o_busy;

    modport slave (
        input  i_clear, i_len, i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_sat, o_busy
    );

    modport master (
        output i_clear, i_len, i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_sat, o_busy
    );
endinterface

// File: rtl/signed_sat_accumulator.sv
// Frame accumulator: sums i_len signed samples into a saturating ACC_W-bit
// result with a sticky overflow flag, presented on a valid/ready output.
package primitives_pkg;
    typedef logic signed [15:0] slogic16_t;
    typedef logic signed [31:0] slogic32_t;
    typedef logic        [7:0]  ulogic8_t;
endpackage

module signed_sat_accumulator
    import primitives_pkg::*;
#(
    parameter int IN_W  = $bits(slogic16_t),
    parameter int ACC_W = $bits(slogic32_t),
    parameter int CNT_W = $bits(ulogic8_t)
) (
    input  logic                    clk,
    input  logic                    rst,
    signed_sat_accumulator_if.slave bus
);

    if (ACC_W <= IN_W) begin : g_bad_width
        $error("signed_sat_accumulator: ACC_W must exceed IN_W");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    localparam logic [CNT_W:0] CNT_ONE  = (CNT_W+1)'(1);
    localparam logic [CNT_W:0] CNT_FULL = {1'b1, {CNT_W{1'b0}}};

    state_t state, state_nxt;

    logic signed [ACC_W-1:0] acc_p1, acc_nxt;
    logic        [CNT_W:0]   cnt_p1, cnt_nxt;
    logic        [CNT_W:0]   len_p1, len_nxt;
    logic                    sat_p1, sat_nxt;

    logic                    accept;
    logic        [CNT_W:0]   len_in;
    logic        [CNT_W:0]   cnt_inc;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W:0]   sum_p0;

    // The sum of an ACC_W value and a narrower sample always fits in ACC_W+1
    // bits, so disagreeing top two bits flag overflow exactly.
    function automatic logic is_ovf(input logic signed [ACC_W:0] s);
        return s[ACC_W] ^ s[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
        logic signed [ACC_W-1:0] r;
        if (!is_ovf(s))
            r = s[ACC_W-1:0];
        else if (s[ACC_W])
            r = {1'b1, {(ACC_W-1){1'b0}}};
        else
            r = {1'b0, {(ACC_W-1){1'b1}}};
        return r;
    endfunction

    assign accept     = bus.i_valid && (state != OUTPUT);
    assign len_in     = (bus.i_len == '0) ? CNT_FULL : {1'b0, bus.i_len};
    assign cnt_inc    = cnt_p1 + CNT_ONE;
    assign sample_ext = {{(ACC_W-IN_W){bus.i_data[IN_W-1]}}, bus.i_data};
    assign sum_p0     = {acc_p1[ACC_W-1], acc_p1} + {sample_ext[ACC_W-1], sample_ext};

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc_p1;
        cnt_nxt   = cnt_p1;
        len_nxt   = len_p1;
        sat_nxt   = sat_p1;
        if (bus.i_clear) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            sat_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        len_nxt   = len_in;
                        acc_nxt   = sample_ext;
                        cnt_nxt   = CNT_ONE;
                        state_nxt = (len_in == CNT_ONE) ? OUTPUT : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_nxt = sat_acc(sum_p0);
                        sat_nxt = sat_p1 | is_ovf(sum_p0);
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == len_p1)
                            state_nxt = OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (bus.i_ready) begin
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        sat_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ---- accumulate stage: registered frame sum, count, length, sticky flag ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p1 <= '0;
            cnt_p1 <= '0;
            len_p1 <= '0;
            sat_p1 <= 1'b0;
        end else begin
            acc_p1 <= acc_nxt;
            cnt_p1 <= cnt_nxt;
            len_p1 <= len_nxt;
            sat_p1 <= sat_nxt;
        end
    end

    // Handshake outputs depend on registered state only.
    assign bus.o_valid = (state == OUTPUT);
    assign bus.o_ready = (state != OUTPUT);
    assign bus.o_busy  = (state != IDLE);
    assign bus.o_data  = acc_p1;
    assign bus.o_sat   = sat_p1;

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Randomized bench for signed_sat_accumulator against a frame-level
// reference model (clamped running sum per frame) kept in the bench.
module tb_signed_sat_accumulator;
    localparam int IN_W  = 16;
    localparam int ACC_W = 17;
    localparam int CNT_W = 8;
    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    signed_sat_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    signed_sat_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    longint fixed_q[$];

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint next_sample();
        logic signed [IN_W-1:0] r;
        if (fixed_q.size() > 0) return fixed_q.pop_front();
        case ($urandom_range(3))
            0:       return 32767;
            1:       return -32768;
            default: begin
                r = IN_W'($urandom);
                return longint'(r);
            end
        endcase
    endfunction

    // One frame. end_mode: 0 = result handshake, 1 = i_clear in OUTPUT, 2 = async rst in OUTPUT.
    // Entered and left at a falling edge with the DUT idle.
    task automatic run_frame(input int len, input int gap_pct, input int hold, input int end_mode);
        int     n    = (len == 0) ? (1 << CNT_W) : len;
        int     sent = 0;
        longint acc  = 0;
        bit     sat  = 1'b0;
        longint x    = 0;
        bus.i_ready = (hold == 0 && end_mode == 0);
        bus.i_clear = 1'b0;
        while (sent < n) begin
            chk("ready_in_frame", bus.o_ready, 1);
            chk("no_early_valid", bus.o_valid, 0);
            chk("busy_in_frame", bus.o_busy, (sent > 0));
            bus.i_len = (sent == 0) ? CNT_W'(len) : CNT_W'($urandom);
            if ($urandom_range(99) < gap_pct) begin
                bus.i_valid = 1'b0;
                bus.i_data  = IN_W'($urandom);
            end else begin
                x = next_sample();
                bus.i_valid = 1'b1;
                bus.i_data  = IN_W'(x);
            end
            @(posedge clk);
            if (bus.i_valid) begin
                acc = acc + x;
                if (acc > ACC_MAX) begin acc = ACC_MAX; sat = 1'b1; end
                else if (acc < ACC_MIN) begin acc = ACC_MIN; sat = 1'b1; end
                sent++;
            end
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        chk("result_valid", bus.o_valid, 1);
        chk("result_data", $signed(bus.o_data), acc);
        chk("result_sat", bus.o_sat, sat);
        chk("result_ready_low", bus.o_ready, 0);
        chk("result_busy", bus.o_busy, 1);
        for (int h = 0; h < hold; h++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = IN_W'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", bus.o_valid, 1);
            chk("hold_data", $signed(bus.o_data), acc);
            chk("hold_sat", bus.o_sat, sat);
            chk("hold_ready_low", bus.o_ready, 0);
        end
        bus.i_valid = 1'b0;
        case (end_mode)
            1: begin
                bus.i_clear = 1'b1;
                @(posedge clk);
                @(negedge clk);
                bus.i_clear = 1'b0;
                chk("out_clear_valid", bus.o_valid, 0);
                chk("out_clear_busy", bus.o_busy, 0);
                chk("out_clear_data", $signed(bus.o_data), 0);
            end
            2: begin
                #2 rst = 1'b1;
                #1;
                chk("async_rst_valid", bus.o_valid, 0);
                chk("async_rst_busy", bus.o_busy, 0);
                chk("async_rst_data", $signed(bus.o_data), 0);
                chk("async_rst_ready", bus.o_ready, 1);
                @(negedge clk);
                rst = 1'b0;
            end
            default: begin
                bus.i_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("post_hs_valid", bus.o_valid, 0);
                chk("post_hs_busy", bus.o_busy, 0);
                chk("post_hs_ready", bus.o_ready, 1);
            end
        endcase
        bus.i_ready = 1'b0;
    endtask

    // Start a frame of len, abort it with i_clear after n_acc accepts.
    task automatic run_clear(input int len, input int n_acc);
        bus.i_ready = 1'b1;
        for (int k = 0; k < n_acc; k++) begin
            bus.i_len   = (k == 0) ? CNT_W'(len) : CNT_W'($urandom);
            bus.i_valid = 1'b1;
            bus.i_data  = IN_W'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        bus.i_clear = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 16'sd1000;
        @(posedge clk);
        @(negedge clk);
        bus.i_clear = 1'b0;
        bus.i_valid = 1'b0;
        chk("clear_busy", bus.o_busy, 0);
        chk("clear_valid", bus.o_valid, 0);
        chk("clear_ready", bus.o_ready, 1);
        chk("clear_data", $signed(bus.o_data), 0);
        bus.i_ready = 1'b0;
    endtask

    initial begin
        int len;
        rst         = 1'b1;
        bus.i_clear = 1'b0;
        bus.i_len   = '0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_valid", bus.o_valid, 0);
        chk("reset_ready", bus.o_ready, 1);
        chk("reset_busy", bus.o_busy, 0);
        chk("reset_data", $signed(bus.o_data), 0);
        chk("reset_sat", bus.o_sat, 0);
        rst = 1'b0;
        @(negedge clk);

        fixed_q = '{10, -3, 7, 100};
        run_frame(4, 0, 0, 0);

        fixed_q = '{32767, 32767, 32767};
        run_frame(3, 0, 0, 0);
        fixed_q = '{5, -5};
        run_frame(2, 0, 0, 0);

        fixed_q = '{-32768, -32768, -32768, 32767};
        run_frame(4, 0, 0, 0);

        run_frame(2, 0, 6, 0);

        run_clear(5, 3);
        fixed_q = '{-8};
        run_frame(1, 0, 0, 0);

        fixed_q.delete();
        for (int k = 0; k < 256; k++) fixed_q.push_back(1);
        run_frame(0, 0, 0, 0);

        run_frame(3, 0, 2, 2);
        run_frame(4, 20, 0, 0);

        run_frame(3, 10, 1, 1);
        run_frame(2, 0, 0, 0);

        for (int f = 0; f < 40; f++) begin
            len = ($urandom_range(19) == 0) ? 0 : int'($urandom_range(20, 1));
            run_frame(len, int'($urandom_range(30)), int'($urandom_range(3)),
                      ($urandom_range(9) == 0) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
